// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM main controller: FSM state encoding and
// SDRAM command word layout {cs_n, ras_n, cas_n, we_n, ba, addr}.
package sdram_pkg;

    // One-hot controller states
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_INIT  = 6'b000010,
        ST_ARB   = 6'b000100,
        ST_REF   = 6'b001000,
        ST_WRITE = 6'b010000,
        ST_READ  = 6'b100000
    } state_e;

    // Control nibble sits above {ba, addr}; bit positions within that nibble
    localparam int         CMD_CTRL_W   = 4;
    localparam int         CTRL_CS_N    = 3;
    localparam int         CTRL_RAS_N   = 2;
    localparam int         CTRL_CAS_N   = 1;
    localparam int         CTRL_WE_N    = 0;
    localparam logic [3:0] CMD_NOP_CTRL = 4'b0111;

    // Total command word width for a given bank/address geometry
    function automatic int cmd_width(input int ba_w, input int addr_w);
        return CMD_CTRL_W + ba_w + addr_w;
    endfunction

endpackage

// File: rtl/sdram_rr_arb.sv
// Round-robin picker: returns the first requesting channel at or after ptr_i,
// both as a one-hot vector and as an index.
module sdram_rr_arb #(
    parameter  int NCH   = 2,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]   req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NCH-1:0]   gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites the others
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] ch_idx;
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = |req_i;
        sum    = '0;
        ch_idx = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NCH)) begin
                sum = sum - (IDX_W+1)'(NCH);
            end
            ch_idx = sum[IDX_W-1:0];
            if (req_i[ch_idx]) begin
                gnt_o         = '0;
                gnt_o[ch_idx] = 1'b1;
                idx_o         = ch_idx;
            end
        end
    end

endmodule

// File: rtl/sdram_arb_main_ctrl.sv
// SDRAM main controller: power-up init sequencing, refresh-first arbitration
// against round-robin user channels, refresh break of running bursts, refresh
// starvation flag and a registered command mux over the engine command buses.
module sdram_arb_main_ctrl
    import sdram_pkg::*;
#(
    parameter  int NCH      = 2,
    parameter  int BA_W     = 2,
    parameter  int ADDR_W   = 12,
    parameter  int REF_LATE = 64,
    localparam int CMD_W    = cmd_width(BA_W, ADDR_W)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_end_i,
    input  logic [CMD_W-1:0] init_cmd_i,
    input  logic             ref_req_i,
    output logic             ref_en_o,
    input  logic             ref_end_i,
    input  logic [CMD_W-1:0] ref_cmd_i,
    input  logic [NCH-1:0]   ch_req_i,
    input  logic [NCH-1:0]   ch_we_i,
    output logic [NCH-1:0]   ch_gnt_o,
    output logic             wr_en_o,
    output logic             wr_brk_o,
    input  logic             wr_end_i,
    input  logic [CMD_W-1:0] wr_cmd_i,
    output logic             rd_en_o,
    output logic             rd_brk_o,
    input  logic             rd_end_i,
    input  logic [CMD_W-1:0] rd_cmd_i,
    output logic             init_busy_o,
    output logic             ref_late_o,
    output logic [CMD_W-1:0] cmd_o
);

    localparam int               IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int               LATE_W  = $clog2(REF_LATE + 1);
    localparam logic [CMD_W-1:0] CMD_NOP = {CMD_NOP_CTRL, {(CMD_W-CMD_CTRL_W){1'b0}}};

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [NCH-1:0]     ch_gnt_q;
    logic               ref_en_q, wr_en_q, rd_en_q;
    logic               wr_brk_q, rd_brk_q;
    logic               ref_late_q;
    logic [LATE_W-1:0]  late_cnt_q, late_cnt_d;
    logic [CMD_W-1:0]   cmd_q;

    logic [NCH-1:0]     win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic [IDX_W-1:0]   rr_next;
    logic               start_burst;
    logic               burst_done;

    sdram_rr_arb #(
        .NCH   (NCH)
    ) u_rr_arb (
        .req_i (ch_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_onehot),
        .idx_o (win_idx),
        .any_o (any_req)
    );

    assign rr_next     = (win_idx == IDX_W'(NCH - 1)) ? '0 : win_idx + 1'b1;
    assign start_burst = (state_q == ST_ARB) && ((state_d == ST_WRITE) || (state_d == ST_READ));
    assign burst_done  = ((state_q == ST_WRITE) || (state_q == ST_READ)) && (state_d == ST_ARB);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: refresh wins in ARB, otherwise the round-robin winner's direction
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_INIT;
            ST_INIT:  if (init_end_i) state_d = ST_ARB;
            ST_ARB: begin
                if (ref_req_i) begin
                    state_d = ST_REF;
                end else if (any_req) begin
                    state_d = ch_we_i[win_idx] ? ST_WRITE : ST_READ;
                end
            end
            ST_REF:   if (ref_end_i) state_d = ST_ARB;
            ST_WRITE: if (wr_end_i)  state_d = ST_ARB;
            ST_READ:  if (rd_end_i)  state_d = ST_ARB;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Starvation counter: cycles with a pending refresh outside REF, saturating
    always_comb begin
        late_cnt_d = late_cnt_q;
        if (state_q == ST_REF) begin
            late_cnt_d = '0;
        end else if (ref_req_i && (late_cnt_q != LATE_W'(REF_LATE))) begin
            late_cnt_d = late_cnt_q + 1'b1;
        end
    end

    // Registered pulses, grant, break requests, starvation flag and command mux
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ref_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_brk_q   <= 1'b0;
            rd_brk_q   <= 1'b0;
            ch_gnt_q   <= '0;
            rr_ptr_q   <= '0;
            late_cnt_q <= '0;
            ref_late_q <= 1'b0;
            cmd_q      <= CMD_NOP;
        end else begin
            ref_en_q   <= (state_q == ST_ARB) && (state_d == ST_REF);
            wr_en_q    <= (state_q == ST_ARB) && (state_d == ST_WRITE);
            rd_en_q    <= (state_q == ST_ARB) && (state_d == ST_READ);
            // A pending refresh seen during a burst is latched until the engine ends
            wr_brk_q   <= (state_q == ST_WRITE) && (state_d == ST_WRITE) && (wr_brk_q || ref_req_i);
            rd_brk_q   <= (state_q == ST_READ) && (state_d == ST_READ) && (rd_brk_q || ref_req_i);
            if (start_burst) begin
                ch_gnt_q <= win_onehot;
                rr_ptr_q <= rr_next;
            end else if (burst_done) begin
                ch_gnt_q <= '0;
            end
            late_cnt_q <= late_cnt_d;
            ref_late_q <= ref_late_q || (late_cnt_d == LATE_W'(REF_LATE));
            case (state_q)
                ST_INIT:  cmd_q <= init_cmd_i;
                ST_REF:   cmd_q <= ref_cmd_i;
                ST_WRITE: cmd_q <= wr_cmd_i;
                ST_READ:  cmd_q <= rd_cmd_i;
                default:  cmd_q <= CMD_NOP;
            endcase
        end
    end

    assign ref_en_o    = ref_en_q;
    assign wr_en_o     = wr_en_q;
    assign rd_en_o     = rd_en_q;
    assign wr_brk_o    = wr_brk_q;
    assign rd_brk_o    = rd_brk_q;
    assign ch_gnt_o    = ch_gnt_q;
    assign ref_late_o  = ref_late_q;
    assign cmd_o       = cmd_q;
    assign init_busy_o = (state_q == ST_IDLE) || (state_q == ST_INIT);

endmodule

// File: tb/tb_sdram_arb_main_ctrl.sv
// Randomized bench for sdram_arb_main_ctrl. The bench plays the init/refresh/
// write/read engines, a transaction-level model predicts every service start
// (pushed to a queue) plus the expected grant/break/flag/command view, and a
// negedge monitor pops and compares.
module tb_sdram_arb_main_ctrl;

    localparam int NCH      = 2;
    localparam int BA_W     = 2;
    localparam int ADDR_W   = 12;
    localparam int REF_LATE = 64;
    localparam int CMD_W    = 4 + BA_W + ADDR_W;
    localparam logic [CMD_W-1:0] NOP = {4'b0111, {(CMD_W-4){1'b0}}};

    // Service kinds as seen on {ref_en, wr_en, rd_en}
    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_REF  = 3'b100;
    localparam logic [2:0] K_WR   = 3'b010;
    localparam logic [2:0] K_RD   = 3'b001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             init_end = 1'b0;
    logic [CMD_W-1:0] init_cmd = '0, ref_cmd = '0, wr_cmd = '0, rd_cmd = '0;
    logic             ref_req = 1'b0, ref_end = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
    logic [NCH-1:0]   ch_req = '0, ch_we = '0;
    logic             ref_en, wr_en, wr_brk, rd_en, rd_brk, init_busy, ref_late;
    logic [NCH-1:0]   ch_gnt;
    logic [CMD_W-1:0] cmd;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_arb_main_ctrl #(
        .NCH        (NCH),
        .BA_W       (BA_W),
        .ADDR_W     (ADDR_W),
        .REF_LATE   (REF_LATE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_end_i  (init_end),
        .init_cmd_i  (init_cmd),
        .ref_req_i   (ref_req),
        .ref_en_o    (ref_en),
        .ref_end_i   (ref_end),
        .ref_cmd_i   (ref_cmd),
        .ch_req_i    (ch_req),
        .ch_we_i     (ch_we),
        .ch_gnt_o    (ch_gnt),
        .wr_en_o     (wr_en),
        .wr_brk_o    (wr_brk),
        .wr_end_i    (wr_end),
        .wr_cmd_i    (wr_cmd),
        .rd_en_o     (rd_en),
        .rd_brk_o    (rd_brk),
        .rd_end_i    (rd_end),
        .rd_cmd_i    (rd_cmd),
        .init_busy_o (init_busy),
        .ref_late_o  (ref_late),
        .cmd_o       (cmd)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [2:0]     kind;
        logic [NCH-1:0] gnt;
    } start_t;

    start_t exp_q[$];

    // Who currently owns the SDRAM bus in the model's view
    localparam int OWN_BOOT = 0;   // first cycle after reset
    localparam int OWN_INIT = 1;   // init engine until init_end
    localparam int OWN_FREE = 2;   // nobody: decide next service
    localparam int OWN_REF  = 3;
    localparam int OWN_WR   = 4;
    localparam int OWN_RD   = 5;

    int             owner    = OWN_BOOT;
    int             next_ch  = 0;
    int             starve   = 0;
    logic           exp_late = 1'b0;
    logic [NCH-1:0] exp_gnt  = '0;
    logic           exp_wbrk = 1'b0;
    logic           exp_rbrk = 1'b0;
    logic [CMD_W-1:0] exp_cmd = NOP;

    initial begin
        int     w;
        start_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                owner = OWN_BOOT; next_ch = 0; starve = 0; exp_late = 1'b0;
                exp_gnt = '0; exp_wbrk = 1'b0; exp_rbrk = 1'b0; exp_cmd = NOP;
                exp_q.delete();
            end else begin
                // bus shows last cycle's owner command
                case (owner)
                    OWN_INIT: exp_cmd = init_cmd;
                    OWN_REF:  exp_cmd = ref_cmd;
                    OWN_WR:   exp_cmd = wr_cmd;
                    OWN_RD:   exp_cmd = rd_cmd;
                    default:  exp_cmd = NOP;
                endcase
                if (owner == OWN_REF) starve = 0;
                else if (ref_req && starve < REF_LATE) starve++;
                if (starve == REF_LATE) exp_late = 1'b1;
                case (owner)
                    OWN_BOOT: owner = OWN_INIT;
                    OWN_INIT: if (init_end) owner = OWN_FREE;
                    OWN_FREE: begin
                        if (ref_req) begin
                            e.kind = K_REF; e.gnt = '0;
                            exp_q.push_back(e);
                            owner = OWN_REF;
                        end else if (ch_req != '0) begin
                            w = next_ch;
                            for (int k = 0; k < NCH; k++) begin
                                if (ch_req[w]) break;
                                w = (w + 1) % NCH;
                            end
                            e.kind = ch_we[w] ? K_WR : K_RD;
                            e.gnt  = NCH'(1) << w;
                            exp_q.push_back(e);
                            exp_gnt = e.gnt;
                            next_ch = (w + 1) % NCH;
                            owner   = ch_we[w] ? OWN_WR : OWN_RD;
                        end
                    end
                    OWN_REF: if (ref_end) owner = OWN_FREE;
                    OWN_WR: begin
                        if (wr_end) begin
                            owner = OWN_FREE; exp_gnt = '0; exp_wbrk = 1'b0;
                        end else if (ref_req) exp_wbrk = 1'b1;
                    end
                    OWN_RD: begin
                        if (rd_end) begin
                            owner = OWN_FREE; exp_gnt = '0; exp_rbrk = 1'b0;
                        end else if (ref_req) exp_rbrk = 1'b1;
                    end
                    default: owner = OWN_BOOT;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        start_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("cmd", cmd, exp_cmd);
                check("init_busy", init_busy, (owner == OWN_BOOT || owner == OWN_INIT));
                check("ch_gnt", ch_gnt, exp_gnt);
                check("wr_brk", wr_brk, exp_wbrk);
                check("rd_brk", rd_brk, exp_rbrk);
                check("ref_late", ref_late, exp_late);
                if (ref_en || wr_en || rd_en || exp_q.size() != 0) begin
                    if (exp_q.size() == 0) begin
                        e.kind = K_NONE; e.gnt = '0;
                    end else begin
                        e = exp_q.pop_front();
                    end
                    check("start_kind", {ref_en, wr_en, rd_en}, e.kind);
                    if (e.kind != K_NONE) begin
                        check("start_gnt", ch_gnt, e.gnt);
                        $display("[TB] t=%0t start kind=%b gnt=%b", $time, e.kind, e.gnt);
                    end
                end
            end
        end
    end

    // ---------------- engines + stimulus ----------------
    logic honor_brk = 1'b1;
    logic long_mode = 1'b0;
    logic rd_only   = 1'b0;
    logic req_on    = 1'b0;
    int   ref_pct   = 0;
    logic ref_act = 1'b0, wr_act = 1'b0, rd_act = 1'b0;
    int   ref_left = 0, wr_left = 0, rd_left = 0;

    function automatic int burst_len();
        return long_mode ? 70 : int'($urandom_range(1, 16));
    endfunction

    task automatic engines_reset();
        ref_act = 1'b0; wr_act = 1'b0; rd_act = 1'b0;
        ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        ref_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        init_cmd = CMD_W'($urandom);
        ref_cmd  = CMD_W'($urandom);
        wr_cmd   = CMD_W'($urandom);
        rd_cmd   = CMD_W'($urandom);
        if (rst) begin
            engines_reset();
        end else begin
            ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
            if (ref_en) begin ref_req = 1'b0; ref_act = 1'b1; ref_left = $urandom_range(1, 6); end
            if (wr_en)  begin wr_act = 1'b1; wr_left = burst_len(); end
            if (rd_en)  begin rd_act = 1'b1; rd_left = burst_len(); end
            if (ref_act) begin
                ref_left--;
                if (ref_left == 0) begin ref_end = 1'b1; ref_act = 1'b0; end
            end else if ($urandom_range(0, 99) < 3) ref_end = 1'b1;
            if (wr_act) begin
                if (wr_brk && honor_brk && wr_left > 2) wr_left = 2;
                wr_left--;
                if (wr_left == 0) begin wr_end = 1'b1; wr_act = 1'b0; end
            end else if ($urandom_range(0, 99) < 3) wr_end = 1'b1;
            if (rd_act) begin
                if (rd_brk && honor_brk && rd_left > 2) rd_left = 2;
                rd_left--;
                if (rd_left == 0) begin rd_end = 1'b1; rd_act = 1'b0; end
            end else if ($urandom_range(0, 99) < 3) rd_end = 1'b1;
            if (!ref_req && !ref_act && $urandom_range(0, 99) < ref_pct) ref_req = 1'b1;
            if (!req_on) begin
                ch_req = '0;
            end else if (long_mode) begin
                ch_req = NCH'(1); ch_we = '0;
            end else if ($urandom_range(0, 99) < 25) begin
                ch_req = NCH'($urandom);
                ch_we  = rd_only ? '0 : NCH'($urandom);
            end
        end
    endtask

    initial begin
        int waited;
        repeat (3) step();
        rst = 1'b0;
        check("rst_init_busy", init_busy, 1'b1);
        check("rst_cmd_nop", cmd, NOP);
        check("rst_gnt", ch_gnt, '0);
        repeat (20) step();
        init_end = 1'b1;
        req_on = 1'b1; ref_pct = 4;
        repeat (2000) step();
        check("late_clear_before_starve", ref_late, 1'b0);

        // long read ignoring break: refresh starves past the limit
        long_mode = 1'b1; honor_brk = 1'b0; ref_pct = 30;
        repeat (300) step();
        check("late_set", ref_late, 1'b1);
        long_mode = 1'b0; honor_brk = 1'b1; ref_pct = 4;
        repeat (100) step();
        check("late_sticky", ref_late, 1'b1);

        // reset in the middle of a read burst
        rd_only = 1'b1;
        waited = 0;
        while (!(rd_act && rd_left > 2) && waited < 300) begin
            step();
            waited++;
        end
        check("rd_burst_wait", rd_act, 1'b1);
        #1 rst = 1'b1;
        engines_reset();
        init_end = 1'b0;
        #1;
        check("arst_cmd", cmd, NOP);
        check("arst_gnt", ch_gnt, '0);
        check("arst_rd_en", rd_en, 1'b0);
        check("arst_rd_brk", rd_brk, 1'b0);
        check("arst_init_busy", init_busy, 1'b1);
        check("arst_late", ref_late, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        rd_only = 1'b0;
        repeat (5) step();
        init_end = 1'b1;
        repeat (500) step();

        // drain: no new requests, let engines finish
        req_on = 1'b0; ref_pct = 0;
        repeat (100) step();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
